// File: rtl/pkt_tx.sv
// Serial packet transmitter: frames each 64-bit word as preamble, sync word, payload and a
// forced-zero gap, shifting one bit per sh_en strobe out of a one-deep holding buffer.
module pkt_tx #(
   parameter int unsigned       PRE_LEN   = 8,
   parameter int unsigned       SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hD3,
   parameter int unsigned       GAP_LEN   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sh_en,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        rfout,
   output logic        busy,
   output logic        pkt_sent
);

   typedef enum logic [2:0] {StIdle, StPre, StSync, StPay, StGap} state_e;

   localparam logic [6:0] PreLen  = 7'(PRE_LEN);
   localparam logic [6:0] SyncLen = 7'(SYNC_W);
   localparam logic [6:0] GapLen  = 7'(GAP_LEN);
   localparam logic [6:0] PayLen  = 7'd64;
   localparam int unsigned SyncIdxW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

   state_e                r_state;
   logic [6:0]            r_cnt;
   logic [63:0]           r_shreg;
   logic [63:0]           r_hold;
   logic                  r_hold_valid;
   logic                  r_rfout;
   logic                  r_pkt_sent;

   logic                  w_accept;
   logic                  w_start;
   logic [SyncIdxW-1:0]   w_sync_idx;

   assign w_accept   = din_valid & ~r_hold_valid;
   // A new frame starts from IDLE, or directly off the last gap period when a word is waiting.
   assign w_start    = sh_en & r_hold_valid &
                       ((r_state == StIdle) | ((r_state == StGap) & (r_cnt >= GapLen)));
   assign w_sync_idx = SyncIdxW'(SyncLen - 7'd1 - r_cnt);

   assign din_ready = ~r_hold_valid;
   assign rfout     = r_rfout;
   assign busy      = (r_state != StIdle);
   assign pkt_sent  = r_pkt_sent;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
      end else if (w_accept) begin
         r_hold       <= din;
         r_hold_valid <= 1'b1;
      end else if (w_start) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_shreg    <= '0;
         r_rfout    <= 1'b0;
         r_pkt_sent <= 1'b0;
      end else begin
         r_pkt_sent <= 1'b0;
         if (w_start) begin
            r_shreg <= r_hold;
            r_rfout <= 1'b1;
            r_cnt   <= 7'd1;
            r_state <= StPre;
         end else if (sh_en) begin
            unique case (r_state)
               StIdle: r_rfout <= 1'b0;
               StPre: begin
                  if (r_cnt < PreLen) begin
                     r_rfout <= ~r_cnt[0];
                     r_cnt   <= r_cnt + 7'd1;
                  end else begin
                     r_rfout <= SYNC_WORD[SYNC_W-1];
                     r_cnt   <= 7'd1;
                     r_state <= StSync;
                  end
               end
               StSync: begin
                  if (r_cnt < SyncLen) begin
                     r_rfout <= SYNC_WORD[w_sync_idx];
                     r_cnt   <= r_cnt + 7'd1;
                  end else begin
                     r_rfout <= r_shreg[63];
                     r_shreg <= {r_shreg[62:0], 1'b0};
                     r_cnt   <= 7'd1;
                     r_state <= StPay;
                  end
               end
               StPay: begin
                  if (r_cnt < PayLen) begin
                     r_rfout <= r_shreg[63];
                     r_shreg <= {r_shreg[62:0], 1'b0};
                     r_cnt   <= r_cnt + 7'd1;
                  end else begin
                     r_rfout    <= 1'b0;
                     r_pkt_sent <= 1'b1;
                     r_cnt      <= 7'd1;
                     r_state    <= StGap;
                  end
               end
               StGap: begin
                  r_rfout <= 1'b0;
                  if (r_cnt < GapLen) begin
                     r_cnt <= r_cnt + 7'd1;
                  end else begin
                     r_state <= StIdle;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: doc/pkt_tx.md
# pkt_tx

Serial packet transmitter for the 64-bit RF link. It accepts 64-bit words through a valid/ready handshake into a one-deep holding buffer. Each word is framed as preamble, then sync word, then payload, and shifted out on `rfout` one bit per `sh_en` strobe. It is the transmit-side counterpart of the link's sync-detect / dual shift-buffer receive path, and its framing must be detectable by that path.

## Interface
Parameters:
- `PRE_LEN`, default 8: number of preamble bits, alternating 1,0,1,0… starting with 1; legal range 2–32.
- `SYNC_W`, default 8: sync word width.
- `SYNC_WORD`, default 8'hD3: sync pattern, sent MSB first.
- `GAP_LEN`, default 4: number of forced-0 bit periods after each packet; legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `sh_en` input 1: bit strobe; the serial output advances only on edges where `sh_en`=1.
- `din` input 64: payload word, sent MSB (bit 63) first.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: holding buffer empty; equals ~hold_valid.
- `rfout` output 1: registered serial line; 0 when idle.
- `busy` output 1: FSM not in IDLE.
- `pkt_sent` output 1: one-clock pulse when the last payload bit's period ends.

## Operation
- Holding buffer: a word is accepted on an edge with `din_valid`=1 and `din_ready`=1, which sets hold_valid. `din_valid` is ignored while `din_ready`=0, and the held word is not overwritten.
- FSM states: IDLE, PRE, SYNC, PAY, GAP. A 7-bit bit counter and a 64-bit shift register are used.
- IDLE:
  - `rfout`=0.
  - On an edge with `sh_en`=1 and hold_valid=1: copy the held word into the shift register, clear hold_valid, drive `rfout`=1 (preamble bit 0), set cnt=1, go to PRE.
- PRE, on each `sh_en` edge:
  - If cnt<PRE_LEN: `rfout`=cnt[0]?0:1, cnt++.
  - Otherwise: `rfout`=SYNC_WORD[SYNC_W-1], cnt=1, go to SYNC.
- SYNC, on each `sh_en` edge:
  - If cnt<SYNC_W: `rfout`=SYNC_WORD[SYNC_W-1-cnt], cnt++.
  - Otherwise: `rfout`=shreg[63], shift left, cnt=1, go to PAY.
- PAY, on each `sh_en` edge:
  - If cnt<64: `rfout`=shreg[63], shift left, cnt++.
  - Otherwise: `rfout`=0, `pkt_sent`=1 for this one clock, cnt=1, go to GAP.
- GAP, on each `sh_en` edge:
  - If cnt<GAP_LEN: `rfout`=0, cnt++.
  - Otherwise: go to IDLE. On the same edge, start the next packet immediately if hold_valid=1 (same action as IDLE).
- Edges with `sh_en`=0 hold all of: state, cnt, shreg, `rfout`. The handshake still operates on those edges.
- Simultaneous accept and transfer: not possible on the same edge, because acceptance requires hold_valid=0. `din_ready` returns to 1 on the clock after the transfer into the shift register. A new word can therefore be held during the whole current frame, which gives gapless back-to-back frames separated only by GAP_LEN.
- Reset (rst=0) is asynchronous and valid at any point, including mid-frame:
  - State→IDLE, cnt=0, shreg=0, hold_valid=0.
  - `rfout`=0, `pkt_sent`=0, `busy`=0, `din_ready`=1.
  - A partially sent frame is dropped and not resumed. Reset release must be synchronized externally to `clk`.

## Timing
- Frame length = PRE_LEN+SYNC_W+64 bit periods, plus GAP_LEN zero periods. With defaults: 80+4 = 84 `sh_en` strobes.
- Latency: the first preamble bit appears on `rfout` at the first `sh_en` edge after hold_valid=1. With `sh_en` held at 1 this is the edge after acceptance: 1 clk.
- Each `rfout` value is stable from its `sh_en` edge until the next `sh_en` edge.
- `pkt_sent` is asserted in the clock following the edge that ends the 64th payload bit period. It lasts one `clk` cycle, regardless of `sh_en` rate.
- `busy` is registered with the state: 1 from the edge that leaves IDLE through the edge that returns to IDLE.

## Test plan
- Single packet, defaults, `sh_en`=1 constant, din=64'hDEADBEEF_01234567:
  - `rfout` sequence is 10101010, then 11010011, then the din bits MSB first, then 0000.
  - `pkt_sent` pulses once, 80 clocks after the first preamble bit.
  - `busy` falls after the gap.
- Back-to-back: present word A, then word B while A is sending:
  - B is accepted; `din_ready`=0 until A's transfer into the shift register.
  - B's preamble starts exactly GAP_LEN periods after A's last bit.
  - Two `pkt_sent` pulses, 84 clocks apart.
- `sh_en`=1 every 4th clock:
  - Every `rfout` value is held for 4 clocks.
  - Frame spans 336 clocks; bit content is identical to the constant-`sh_en` case.
- Full buffer: hold_valid=1 and `din_valid`=1 with a different din:
  - The new word is ignored; the originally held word is transmitted unchanged.
- Reset asserted mid-payload (bit 30), then released:
  - `rfout`=0, `busy`=0, `din_ready`=1 immediately, with no clock edge needed.
  - No `pkt_sent` pulse.
  - The next accepted word is sent as a full frame starting with its preamble.
- Loopback into the link's receive path:
  - Random words, 100 frames.
  - Every word is recovered bit-exact with one receive strobe per `pkt_sent`.
